// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared widths, arbiter state encoding and fairness helper.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 32;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 8;

  // Back-to-back data grants tolerated while a fetch is waiting.
  localparam logic [1:0] STREAK_MAX = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  function automatic logic [1:0] streak_next(input logic [1:0] cur,
                                             input logic       if_waiting);
    logic [1:0] nxt;
    nxt = 2'd0;
    if (if_waiting) begin
      nxt = (cur == STREAK_MAX) ? cur : cur + 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timeout.sv
`default_nettype none
// ============================================================================
// Module      : arb_timeout
// Description : Counts stalled memory cycles; flags the last allowed one.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_timeout
  import proc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires during the TIMEOUT-th waiting cycle so mem_req is held exactly TIMEOUT cycles.
  assign expired = en & (r_count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  state_t     r_state;
  logic [1:0] r_streak;

  logic w_if_pending;
  logic w_dm_pending;
  logic w_any_valid;
  logic w_grant_fetch;
  logic w_grant_data;
  logic w_wait_en;
  logic w_done;
  logic w_expired;

  assign w_if_pending = if_req & ~if_valid;
  assign w_dm_pending = (dm_re | dm_we) & ~dm_valid;

  // No grant at all in a completion cycle: gives the finished requester one
  // cycle to present its next access before the other port can slip in.
  assign w_any_valid   = if_valid | dm_valid;
  assign w_grant_fetch = (r_state == ST_IDLE) & ~w_any_valid & w_if_pending &
                         (~w_dm_pending | (r_streak == STREAK_MAX));
  assign w_grant_data  = (r_state == ST_IDLE) & ~w_any_valid & w_dm_pending &
                         ~w_grant_fetch;

  assign w_wait_en = mem_req & ~mem_ack;
  assign w_done    = mem_req & mem_ack;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = (dm_re | dm_we) & ~dm_valid;

  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (w_wait_en),
    .clr     (w_grant_fetch | w_grant_data),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_streak  <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_fetch) begin
            r_state   <= ST_FETCH;
            r_streak  <= 2'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (w_grant_data) begin
            r_state   <= ST_DATA;
            r_streak  <= streak_next(r_streak, w_if_pending);
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end
        end
        ST_FETCH: begin
          if (w_done) begin
            r_state  <= ST_IDLE;
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end else if (w_expired) begin
            r_state  <= ST_IDLE;
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= '0;
            err      <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_state  <= ST_IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end else if (w_expired) begin
            r_state  <= ST_IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            dm_rdata <= '0;
            err      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_re = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  mem_port_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit fetch; logic [31:0] rdata; } exp_t;
  typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; } gnt_t;

  exp_t exp_q[$];
  gnt_t gnt_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int if_valid_cyc = 0;
  int dm_valid_cyc = 0;
  int last_rise_cyc = 0;
  logic        prev_req = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_wdata = '0;
  logic        hold_we = 1'b0;
  logic [31:0] model_dm = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic check_resp(input bit fetch, input logic [31:0] rdata);
    exp_t e;
    if (exp_q.size() == 0) begin
      fail_now(fetch ? "unexpected_if_valid" : "unexpected_dm_valid");
    end else begin
      e = exp_q.pop_front();
      chk("valid_port", 32'(fetch), 32'(e.fetch));
      chk(fetch ? "if_rdata" : "dm_rdata", rdata, e.rdata);
    end
  endtask

  // Monitor: completions against the response scoreboard, grants against the
  // grant scoreboard, and request stability while mem_req is held.
  always @(negedge clk) begin
    gnt_t g;
    if (!rst) begin
      chk("if_stall", 32'(if_stall), 32'(if_req & ~if_valid));
      chk("dm_stall", 32'(dm_stall), 32'((dm_re | dm_we) & ~dm_valid));
      if (if_valid) begin
        if_valid_cyc = cyc;
        check_resp(1'b1, if_rdata);
      end
      if (dm_valid) begin
        dm_valid_cyc = cyc;
        check_resp(1'b0, dm_rdata);
      end
      if (mem_req && !prev_req) begin
        last_rise_cyc = cyc;
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
        if (gnt_q.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          g = gnt_q.pop_front();
          chk("grant_addr", mem_addr, g.addr);
          chk("grant_we", 32'(mem_we), 32'(g.we));
          if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
        end
      end else if (mem_req && prev_req) begin
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_we", 32'(mem_we), 32'(hold_we));
        chk("hold_wdata", mem_wdata, hold_wdata);
      end
    end
    prev_req = mem_req;
  end

  task automatic wait_valid(input bit fetch);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(fetch ? if_valid : dm_valid) && w < 100);
    if (!(fetch ? if_valid : dm_valid)) fail_now("wait_valid");
  endtask

  task automatic fetch(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    wait_valid(1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    dm_addr = a;
    dm_re   = 1'b1;
    wait_valid(1'b0);
    @(posedge clk); #1;
    dm_re = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dm_addr  = a;
    dm_wdata = d;
    dm_we    = 1'b1;
    dm_re    = 1'b1;
    wait_valid(1'b0);
    @(posedge clk); #1;
    dm_we = 1'b0;
    dm_re = 1'b0;
  endtask

  // Memory model: acks in the n-th cycle of mem_req.
  task automatic serve(input int n, input logic [31:0] rd);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_req && w < 100);
    if (!mem_req) begin
      fail_now("serve_wait_req");
    end else begin
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        chk("req_held", 32'(mem_req), 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("req_dropped", 32'(mem_req), 32'd0);
    end
  endtask

  task automatic count_req(output int cnt);
    int w;
    w = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_req && w < 100);
    if (mem_req) begin
      cnt = 1;
      w = 0;
      forever begin
        @(negedge clk);
        w++;
        if (!mem_req || w > 40) break;
        cnt++;
      end
    end
  endtask

  task automatic push_load(input logic [31:0] a, input logic [31:0] rd);
    gnt_q.push_back('{a, 1'b0, 32'h0});
    exp_q.push_back('{1'b0, rd});
    model_dm = rd;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] rd);
    gnt_q.push_back('{a, 1'b0, 32'h0});
    exp_q.push_back('{1'b1, rd});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int req_cyc;
    int w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, ack in third request cycle.
    push_fetch(32'h100, 32'hDEADBEEF);
    fork
      fetch(32'h100);
      serve(3, 32'hDEADBEEF);
    join
    repeat (2) @(negedge clk);
    chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Simultaneous fetch and load: data first, fetch two cycles after dm_valid.
    push_load(32'h200, 32'h11112222);
    push_fetch(32'h500, 32'h33334444);
    fork
      load(32'h200);
      fetch(32'h500);
      begin serve(2, 32'h11112222); serve(1, 32'h33334444); end
    join
    chk("fetch_after_dm", 32'(last_rise_cyc - dm_valid_cyc), 32'd2);
    @(posedge clk); #1;

    // Three loads with fetch held: DATA, DATA, FETCH, DATA.
    push_load(32'hA00, 32'hA0A0A0A0);
    push_load(32'hA04, 32'hA4A4A4A4);
    push_fetch(32'h300, 32'h30303030);
    push_load(32'hA08, 32'hA8A8A8A8);
    fork
      begin
        dm_addr = 32'hA00;
        dm_re   = 1'b1;
        wait_valid(1'b0);
        @(posedge clk); #1;
        dm_addr = 32'hA04;
        wait_valid(1'b0);
        @(posedge clk); #1;
        dm_addr = 32'hA08;
        wait_valid(1'b0);
        @(posedge clk); #1;
        dm_re = 1'b0;
      end
      fetch(32'h300);
      begin
        serve(1, 32'hA0A0A0A0);
        serve(1, 32'hA4A4A4A4);
        serve(1, 32'h30303030);
        serve(1, 32'hA8A8A8A8);
      end
    join
    @(posedge clk); #1;

    // Store (dm_re also high) at minimum latency; dm_rdata must not change.
    gnt_q.push_back('{32'h40, 1'b1, 32'h12345678});
    exp_q.push_back('{1'b0, model_dm});
    req_cyc = cyc;
    fork
      store(32'h40, 32'h12345678);
      serve(1, 32'hBAD0BAD0);
    join
    chk("min_latency", 32'(dm_valid_cyc - req_cyc), 32'd2);
    @(posedge clk); #1;

    // No ack: timeout after 15 request cycles, rdata 0, sticky err.
    push_fetch(32'h600, 32'h0);
    fork
      fetch(32'h600);
      count_req(n);
    join
    chk("timeout_len", 32'(n), 32'd15);
    chk("err_set", 32'(err), 32'd1);
    @(posedge clk); #1;
    push_load(32'h80, 32'h55AA55AA);
    fork
      load(32'h80);
      serve(2, 32'h55AA55AA);
    join
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;

    // Reset two cycles into a fetch, with ack arriving during and after reset.
    gnt_q.push_back('{32'h700, 1'b0, 32'h0});
    if_addr = 32'h700;
    if_req  = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_req && w < 50);
    chk("rst_fetch_started", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    if_req    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("mid_rst_if_rdata", if_rdata, 32'd0);
    chk("mid_rst_dm_rdata", dm_rdata, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    chk("post_rst_no_valid", 32'(if_valid | dm_valid), 32'd0);
    mem_ack = 1'b0;
    model_dm = 32'h0;
    @(posedge clk); #1;

    push_fetch(32'h704, 32'h0F0F0F0F);
    fork
      fetch(32'h704);
      serve(2, 32'h0F0F0F0F);
    join
    repeat (2) @(negedge clk);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
